calc_bin2bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the calculator's arithmetic units (subtractor, adder, etc.). It captures a 2N-bit result and its error flag, converts the value to packed BCD digits with a shift-and-add-3 (double-dabble) loop at one bit per clock, and presents the digits to the display driver with a start/busy/done handshake.

---
 rtl/calc_bin2bcd_if.sv | 25 ++
 rtl/calc_bin2bcd.sv | 126 ++++++++++++
 tb/tb_calc_bin2bcd.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_bin2bcd_if.sv
// Handshake and data bundle between an arithmetic unit (master) and the
// calc_bin2bcd converter (slave).
interface calc_bin2bcd_if #(
  parameter int N = 8,
  parameter int D = 5
);
  logic             start;
  logic [2*N-1:0]   bin;
  logic             err;
  logic             busy;
  logic             done;
  logic [4*D-1:0]   bcd;
  logic             neg;
  logic             err_out;

  modport master (
    output start, bin, err,
    input  busy, done, bcd, neg, err_out
  );

  modport slave (
    input  start, bin, err,
    output busy, done, bcd, neg, err_out
  );
endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro CALC_BCD_NEG_EN: treat err as "two's-complement negative" and convert the magnitude.
module calc_bin2bcd #(
  parameter int N = 8,
  parameter int D = 5
) (
  input logic           clk,
  input logic           rst,
  calc_bin2bcd_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          r_state, w_nextState;
  logic [W-1:0]    r_shift, w_mag;
  logic [4*D-1:0]  r_scratch, w_adj, w_shifted, r_bcd;
  logic [CW-1:0]   r_count;
  logic            r_done, r_errOut, r_errCap;
  logic            w_errShort, w_capture, w_errTake, w_shiftEn, w_last, w_busy;

`ifdef CALC_BCD_NEG_EN
  logic            r_neg, r_negCap;
  assign w_errShort = 1'b0;
  assign w_mag      = bus.err ? -bus.bin : bus.bin;
  assign bus.neg    = r_neg;
`else
  assign w_errShort = bus.err;
  assign w_mag      = bus.bin;
  assign bus.neg    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start && !w_errShort) w_nextState = SHIFT;
      SHIFT:   if (r_count == CW'(1))        w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_shiftEn = 1'b0;
    w_last    = 1'b0;
    w_capture = 1'b0;
    w_errTake = 1'b0;
    case (r_state)
      IDLE: begin
        w_capture = bus.start && !w_errShort;
        w_errTake = bus.start && w_errShort;
      end
      SHIFT: begin
        w_busy    = 1'b1;
        w_shiftEn = 1'b1;
        w_last    = (r_count == CW'(1));
      end
      default: ;
    endcase
  end

  // Add-3 correction on every digit that would overflow past 9 after doubling
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < D; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  assign w_shifted = {w_adj[4*D-2:0], r_shift[W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
      r_errOut  <= 1'b0;
      r_errCap  <= 1'b0;
`ifdef CALC_BCD_NEG_EN
      r_neg     <= 1'b0;
      r_negCap  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_shift   <= w_mag;
        r_scratch <= '0;
        r_count   <= CW'(W);
        r_errCap  <= bus.err;
`ifdef CALC_BCD_NEG_EN
        r_negCap  <= bus.err;
`endif
      end else if (w_errTake) begin
        r_bcd    <= '1;
        r_errOut <= 1'b1;
        r_done   <= 1'b1;
      end else if (w_shiftEn) begin
        r_shift   <= r_shift << 1;
        r_scratch <= w_shifted;
        r_count   <= r_count - 1'b1;
        if (w_last) begin
          r_bcd    <= w_shifted;
          r_errOut <= r_errCap;
          r_done   <= 1'b1;
`ifdef CALC_BCD_NEG_EN
          r_neg    <= r_negCap;
`endif
        end
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.bcd     = r_bcd;
  assign bus.err_out = r_errOut;
endmodule

// File: tb/tb_calc_bin2bcd.sv
// Self-checking bench for calc_bin2bcd: vector table, random values against a
// decimal-arithmetic reference, and hand-written handshake/reset sequences.
module tb_calc_bin2bcd;
  localparam int N   = 8;
  localparam int D   = 5;
  localparam int W   = 2 * N;
  localparam int BW  = 4 * D;
  localparam int LAT = W + 1;
  localparam int MAXCYC = 60;

  typedef struct {
    logic [W-1:0]  bin;
    logic          err;
    logic [BW-1:0] bcd;
    logic          neg;
    logic          errOut;
    int            lat;
    int            busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  calc_bin2bcd_if #(.N(N), .D(D)) bus ();
  calc_bin2bcd #(.N(N), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] refBcd(input longint unsigned v);
    logic [BW-1:0]   r;
    longint unsigned div;
    r   = '0;
    div = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic vec_t refModel(input logic [W-1:0] b, input logic e);
    vec_t v;
    longint unsigned m;
    v.bin = b;
    v.err = e;
`ifdef CALC_BCD_NEG_EN
    m        = e ? ((longint'(1) << W) - longint'(b)) % (longint'(1) << W) : longint'(b);
    v.bcd    = refBcd(m);
    v.neg    = e;
    v.errOut = e;
    v.lat    = LAT;
    v.busy   = W;
`else
    m = longint'(b);
    if (e) begin
      v.bcd  = '1;
      v.lat  = 1;
      v.busy = 0;
    end else begin
      v.bcd  = refBcd(m);
      v.lat  = LAT;
      v.busy = W;
    end
    v.neg    = 1'b0;
    v.errOut = e;
`endif
    return v;
  endfunction

  // Leaves the bench in the cycle where done was seen (or the bound expired)
  task automatic applyStimulus(input logic [W-1:0] b, input logic e, output int cyc, output int busyCnt);
    bus.start = 1'b1;
    bus.bin   = b;
    bus.err   = e;
    tick();
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
    bus.err   = 1'($urandom);
    cyc     = 1;
    busyCnt = bus.busy ? 1 : 0;
    while (!bus.done && cyc < MAXCYC) begin
      tick();
      cyc++;
      if (bus.busy) busyCnt++;
    end
  endtask

  task automatic checkVector(input string name, input vec_t v);
    int cyc, busyCnt;
    applyStimulus(v.bin, v.err, cyc, busyCnt);
    checkOutput({name, " latency"}, cyc, v.lat);
    checkOutput({name, " busy cycles"}, busyCnt, v.busy);
    checkOutput({name, " bcd"}, 32'(bus.bcd), 32'(v.bcd));
    checkOutput({name, " neg"}, 32'(bus.neg), 32'(v.neg));
    checkOutput({name, " err_out"}, 32'(bus.err_out), 32'(v.errOut));
    tick();
    checkOutput({name, " done width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   cyc, busyCnt, doneCnt;

    tbl.push_back('{16'd12345, 1'b0, 20'h12345, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd0,     1'b0, 20'h00000, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd65535, 1'b0, 20'h65535, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd9,     1'b0, 20'h00009, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd10,    1'b0, 20'h00010, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd1000,  1'b0, 20'h01000, 1'b0, 1'b0, LAT, W});
    tbl.push_back('{16'd59999, 1'b0, 20'h59999, 1'b0, 1'b0, LAT, W});
`ifdef CALC_BCD_NEG_EN
    tbl.push_back('{16'hFFFB,  1'b1, 20'h00005, 1'b1, 1'b1, LAT, W});
    tbl.push_back('{16'h8000,  1'b1, 20'h32768, 1'b1, 1'b1, LAT, W});
    tbl.push_back('{16'hFFFF,  1'b1, 20'h00001, 1'b1, 1'b1, LAT, W});
`else
    tbl.push_back('{16'hFFFB,  1'b1, 20'hFFFFF, 1'b0, 1'b1, 1, 0});
    tbl.push_back('{16'h8000,  1'b1, 20'hFFFFF, 1'b0, 1'b1, 1, 0});
    tbl.push_back('{16'hFFFF,  1'b1, 20'hFFFFF, 1'b0, 1'b1, 1, 0});
`endif

    bus.start = 1'b0;
    bus.bin   = '0;
    bus.err   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset bcd", 32'(bus.bcd), 32'd0);
    checkOutput("reset neg", 32'(bus.neg), 32'd0);
    checkOutput("reset err_out", 32'(bus.err_out), 32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) checkVector($sformatf("table[%0d]", i), tbl[i]);

    for (int i = 0; i < 24; i++) begin
      v = refModel(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 3) == 0));
      checkVector($sformatf("random[%0d] bin=%0d err=%0b", i, v.bin, v.err), v);
    end

    // start re-asserted while busy must be ignored
    bus.start = 1'b1;
    bus.bin   = 16'd250;
    bus.err   = 1'b0;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      tick();
      cyc++;
    end
    bus.start = 1'b1;
    bus.bin   = 16'd999;
    tick();
    cyc++;
    bus.start = 1'b0;
    while (!bus.done && cyc < MAXCYC) begin
      tick();
      cyc++;
    end
    checkOutput("ignore latency", cyc, LAT);
    checkOutput("ignore bcd", 32'(bus.bcd), 32'h00250);
    doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done) doneCnt++;
    end
    checkOutput("ignore extra done", doneCnt, 0);

    // back-to-back: new start in the done cycle
    applyStimulus(16'd123, 1'b0, cyc, busyCnt);
    checkOutput("b2b first bcd", 32'(bus.bcd), 32'h00123);
    bus.start = 1'b1;
    bus.bin   = 16'd42;
    bus.err   = 1'b0;
    tick();
    bus.start = 1'b0;
    checkOutput("b2b done width", 32'(bus.done), 32'd0);
    cyc = 1;
    while (!bus.done && cyc < MAXCYC) begin
      tick();
      cyc++;
    end
    checkOutput("b2b latency", cyc, LAT);
    checkOutput("b2b bcd", 32'(bus.bcd), 32'h00042);
    tick();

    // reset mid-conversion, coinciding with a start request
    bus.start = 1'b1;
    bus.bin   = 16'd777;
    bus.err   = 1'b0;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      tick();
      cyc++;
    end
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.bin   = 16'd555;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("midreset busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset done", 32'(bus.done), 32'd0);
    checkOutput("midreset bcd", 32'(bus.bcd), 32'd0);
    checkOutput("midreset neg", 32'(bus.neg), 32'd0);
    checkOutput("midreset err_out", 32'(bus.err_out), 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done || bus.busy) doneCnt++;
    end
    checkOutput("midreset stale activity", doneCnt, 0);
    checkVector("after reset", refModel(16'd321, 1'b0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
